// File: rtl/sprite_pal_mixer.sv
// sprite_pal_mixer: sprite/background priority mux with dual CPU-writable palettes and a
// 3-stage CE_PIX pipeline to registered RGB888 with matching blanking.
module sprite_pal_mixer #(
  parameter int PAL_AW = 8,
  parameter int COMP_W = 5
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        CE_PIX,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  input  logic [11:1] A,
  input  logic [1:0]  BYTE_SEL,
  input  logic        MRD,
  input  logic        MWR,
  input  logic        SPAL_CS,
  input  logic        BPAL_CS,
  input  logic [7:0]  SPR_PIX,
  input  logic [7:0]  BG_PIX,
  input  logic        BG_OPAQUE,
  input  logic        BG_PRIO,
  input  logic        HBLK,
  input  logic        VBLK,
  input  logic [1:0]  LAYER_EN,
  output logic [7:0]  R_OUT,
  output logic [7:0]  G_OUT,
  output logic [7:0]  B_OUT,
  output logic        HBLK_OUT,
  output logic        VBLK_OUT
);
  localparam int N  = 2**PAL_AW;
  localparam int XW = 8 - COMP_W;

  logic [COMP_W-1:0] r_spal_r [0:N-1];
  logic [COMP_W-1:0] r_spal_g [0:N-1];
  logic [COMP_W-1:0] r_spal_b [0:N-1];
  logic [COMP_W-1:0] r_bpal_r [0:N-1];
  logic [COMP_W-1:0] r_bpal_g [0:N-1];
  logic [COMP_W-1:0] r_bpal_b [0:N-1];

  logic              w_cs_ok, w_we, w_comp3;
  logic [1:0]        w_comp;
  logic [PAL_AW-1:0] w_idx;
  logic [COMP_W-1:0] w_wd, w_rd_s, w_rd_b, w_rd;
  logic [15:0]       r_dout;
  logic              w_unused;

  // Both chip selects at once is treated as a decode fault: no write, reads 0.
  assign w_cs_ok  = SPAL_CS ^ BPAL_CS;
  assign w_comp   = A[10:9];
  assign w_comp3  = (w_comp == 2'd3);
  assign w_idx    = A[PAL_AW:1];
  assign w_wd     = DIN[COMP_W-1:0];
  assign w_we     = MWR & BYTE_SEL[0] & w_cs_ok & ~w_comp3;
  assign w_unused = &{1'b0, A[11], BYTE_SEL[1], DIN[15:COMP_W]};

  always_ff @(posedge CLK_32M) begin
    if (w_we && SPAL_CS && w_comp == 2'd0) r_spal_r[w_idx] <= w_wd;
    if (w_we && SPAL_CS && w_comp == 2'd1) r_spal_g[w_idx] <= w_wd;
    if (w_we && SPAL_CS && w_comp == 2'd2) r_spal_b[w_idx] <= w_wd;
    if (w_we && BPAL_CS && w_comp == 2'd0) r_bpal_r[w_idx] <= w_wd;
    if (w_we && BPAL_CS && w_comp == 2'd1) r_bpal_g[w_idx] <= w_wd;
    if (w_we && BPAL_CS && w_comp == 2'd2) r_bpal_b[w_idx] <= w_wd;
  end

  assign w_rd_s = (w_comp == 2'd0) ? r_spal_r[w_idx] : (w_comp == 2'd1) ? r_spal_g[w_idx] : r_spal_b[w_idx];
  assign w_rd_b = (w_comp == 2'd0) ? r_bpal_r[w_idx] : (w_comp == 2'd1) ? r_bpal_g[w_idx] : r_bpal_b[w_idx];
  assign w_rd   = (!w_cs_ok || w_comp3) ? '0 : SPAL_CS ? w_rd_s : w_rd_b;

  always_ff @(posedge CLK_32M or negedge RESET_N)
    if (!RESET_N) r_dout <= '0;
    else          r_dout <= {{(16-COMP_W){1'b0}}, w_rd};

  assign DOUT       = r_dout;
  assign DOUT_VALID = MRD & (SPAL_CS | BPAL_CS);

  logic              w_spr_vis, w_bg_vis, w_spr_win, w_blank;
  logic [PAL_AW-1:0] w_s1_idx;
  logic              r_s1_sel, r_s1_hb, r_s1_vb;
  logic [PAL_AW-1:0] r_s1_idx;
  logic [COMP_W-1:0] r_s2_r, r_s2_g, r_s2_b;
  logic              r_s2_hb, r_s2_vb;
  logic [7:0]        r_r, r_g, r_b;
  logic              r_hb, r_vb;

  assign w_spr_vis = LAYER_EN[1] & (SPR_PIX[3:0] != 4'd0);
  assign w_bg_vis  = LAYER_EN[0] & BG_OPAQUE;
  assign w_spr_win = w_spr_vis & ~(w_bg_vis & BG_PRIO);
  assign w_s1_idx  = w_spr_win ? SPR_PIX[PAL_AW-1:0] : w_bg_vis ? BG_PIX[PAL_AW-1:0] : '0;
  assign w_blank   = r_s2_hb | r_s2_vb;

  always_ff @(posedge CLK_32M or negedge RESET_N)
    if (!RESET_N) begin
      r_s1_sel <= 1'b0;
      r_s1_idx <= '0;
      r_s1_hb  <= 1'b1;
      r_s1_vb  <= 1'b1;
      r_s2_r   <= '0;
      r_s2_g   <= '0;
      r_s2_b   <= '0;
      r_s2_hb  <= 1'b1;
      r_s2_vb  <= 1'b1;
      r_r      <= '0;
      r_g      <= '0;
      r_b      <= '0;
      r_hb     <= 1'b1;
      r_vb     <= 1'b1;
    end else if (CE_PIX) begin
      r_s1_sel <= w_spr_win;
      r_s1_idx <= w_s1_idx;
      r_s1_hb  <= HBLK;
      r_s1_vb  <= VBLK;
      r_s2_r   <= r_s1_sel ? r_spal_r[r_s1_idx] : r_bpal_r[r_s1_idx];
      r_s2_g   <= r_s1_sel ? r_spal_g[r_s1_idx] : r_bpal_g[r_s1_idx];
      r_s2_b   <= r_s1_sel ? r_spal_b[r_s1_idx] : r_bpal_b[r_s1_idx];
      r_s2_hb  <= r_s1_hb;
      r_s2_vb  <= r_s1_vb;
      // Replicate the top bits into the LSBs so full-scale maps to 0xFF.
      r_r      <= w_blank ? 8'd0 : {r_s2_r, r_s2_r[COMP_W-1 -: XW]};
      r_g      <= w_blank ? 8'd0 : {r_s2_g, r_s2_g[COMP_W-1 -: XW]};
      r_b      <= w_blank ? 8'd0 : {r_s2_b, r_s2_b[COMP_W-1 -: XW]};
      r_hb     <= r_s2_hb;
      r_vb     <= r_s2_vb;
    end

  assign R_OUT    = r_r;
  assign G_OUT    = r_g;
  assign B_OUT    = r_b;
  assign HBLK_OUT = r_hb;
  assign VBLK_OUT = r_vb;
endmodule
